// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: datapath <-> memory-side responder data-port bundle.
//   mem_addr      byte address (ALU result)
//   mem_rd/mem_wr load / store request
//   mem_writedata store data
//   mem_readdata  load data back to the datapath
//   cpu_enable    datapath enable, 0 = hold the PC this cycle
// master = datapath side, slave = responder side.
interface mem_io_responder_if #(
  parameter int Dbits = 32
);
  logic [31:0]      mem_addr;
  logic             mem_rd;
  logic             mem_wr;
  logic [Dbits-1:0] mem_writedata;
  logic [Dbits-1:0] mem_readdata;
  logic             cpu_enable;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_writedata,
    input  mem_readdata, cpu_enable
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_writedata,
    output mem_readdata, cpu_enable
  );
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: data-port responder for a single-cycle MIPS datapath.
// Decodes each access to data RAM (synchronous read, one stall per load),
// a small I/O register bank (LED, CYCLE, STATUS) or unmapped space.
//
// Ports:
//   clk    system clock, all state on posedge
//   reset  synchronous, active-high
//   bus    mem_io_responder_if.slave (addr/rd/wr/writedata in,
//          readdata/cpu_enable out)
//   led    LED register contents
//
// Build option: define STALL_COUNT_EN to add a saturating 16-bit stall
// counter at I/O offset 0xC. Without it 0xC is unmapped.
module mem_io_responder #(
  parameter int          Nloc      = 64,
  parameter int          Dbits     = 32,
  parameter logic [31:0] DMEM_BASE = 32'h1001_0000,
  parameter logic [31:0] IO_BASE   = 32'h1003_0000
) (
  input  logic              clk,
  input  logic              reset,
  mem_io_responder_if.slave bus,
  output logic [15:0]       led
);
  localparam int AW = $clog2(Nloc);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t      state_q, state_d;
  logic [15:0] led_q, led_d;
  logic [31:0] cycle_q, cycle_d;
  logic        err_q, err_d;

  logic [Dbits-1:0] ram_mem [Nloc];
  logic [Dbits-1:0] ram_rdata_q;

  // Address decode
  logic          aligned;
  logic          dmem_hit;
  logic          io_page;
  logic          io_led, io_cyc, io_stat, io_stall, io_hit;
  logic [AW-1:0] ram_idx;

  always_comb begin
    aligned  = (bus.mem_addr[1:0] == 2'b00);
    // Word index must fall inside the RAM; upper page bits alone are not enough.
    dmem_hit = aligned && (bus.mem_addr[31:16] == DMEM_BASE[31:16]) &&
               ({18'd0, bus.mem_addr[15:2]} < 32'(Nloc));
    io_page  = aligned && (bus.mem_addr[31:16] == IO_BASE[31:16]);
    io_led   = io_page && (bus.mem_addr[15:0] == 16'h0000);
    io_cyc   = io_page && (bus.mem_addr[15:0] == 16'h0004);
    io_stat  = io_page && (bus.mem_addr[15:0] == 16'h0008);
`ifdef STALL_COUNT_EN
    io_stall = io_page && (bus.mem_addr[15:0] == 16'h000C);
`else
    io_stall = 1'b0;
`endif
    io_hit   = io_led | io_cyc | io_stat | io_stall;
    ram_idx  = bus.mem_addr[AW+1:2];
  end

  // Request qualification. In LOAD_WAIT the inputs belong to the held lw and
  // are ignored; a store always wins over a same-cycle load.
  logic idle, st_req, ld_req, ram_we, ram_re;

  always_comb begin
    idle   = (state_q == IDLE);
    st_req = idle && bus.mem_wr;
    ld_req = idle && bus.mem_rd && !bus.mem_wr;
    ram_we = st_req && dmem_hit && !reset;
    ram_re = ld_req && dmem_hit;
  end

`ifdef STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;
`endif

  // I/O read mux
  logic [Dbits-1:0] io_rdata;

  always_comb begin
    io_rdata = '0;
    if (io_led)  io_rdata = Dbits'(led_q);
    if (io_cyc)  io_rdata = Dbits'(cycle_q);
    if (io_stat) io_rdata = Dbits'({state_q == LOAD_WAIT, err_q});
`ifdef STALL_COUNT_EN
    if (io_stall) io_rdata = Dbits'(stall_q);
`endif
  end

  // Outputs
  always_comb begin
    bus.cpu_enable = !ram_re;
    if (!idle)                 bus.mem_readdata = ram_rdata_q;
    else if (ld_req && io_hit) bus.mem_readdata = io_rdata;
    else                       bus.mem_readdata = '0;
  end

  assign led = led_q;

  // Next state
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    cycle_d = cycle_q + 32'd1;
    err_d   = err_q;
`ifdef STALL_COUNT_EN
    stall_d = stall_q;
    if (!bus.cpu_enable && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
`endif
    if (!idle) begin
      state_d = IDLE;
    end else if (st_req) begin
      if (dmem_hit) begin
        // RAM write happens in the array block
      end else if (io_led) begin
        led_d = bus.mem_writedata[15:0];
      end else if (io_cyc) begin
        cycle_d = 32'(bus.mem_writedata);
      end else if (io_stat) begin
        if (bus.mem_writedata[0]) err_d = 1'b0;
      end else if (io_stall) begin
`ifdef STALL_COUNT_EN
        stall_d = 16'd0;
`endif
      end else begin
        err_d = 1'b1;
      end
    end else if (ld_req) begin
      if (dmem_hit)     state_d = LOAD_WAIT;
      else if (!io_hit) err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      led_q   <= 16'd0;
      cycle_q <= 32'd0;
      err_q   <= 1'b0;
`ifdef STALL_COUNT_EN
      stall_q <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      cycle_q <= cycle_d;
      err_q   <= err_d;
`ifdef STALL_COUNT_EN
      stall_q <= stall_d;
`endif
    end
  end

  // Data RAM: no reset on contents; write is suppressed under reset so a
  // same-cycle store is dropped. Read data lands in ram_rdata_q for LOAD_WAIT.
  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[ram_idx] <= bus.mem_writedata;
    if (ram_re) ram_rdata_q      <= ram_mem[ram_idx];
  end
endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;
  localparam int NLOC = 64;
  localparam logic [31:0] DB = 32'h1001_0000;

`ifdef STALL_COUNT_EN
  localparam logic [31:0] EXP_STALL = 32'd3;
  localparam logic [31:0] EXP_STAT  = 32'd0;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_STAT  = 32'd1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] led;
  int          checks = 0;
  int          errors = 0;

  mem_io_responder_if #(.Dbits(32)) bus ();

  mem_io_responder #(
    .Nloc(NLOC), .Dbits(32), .DMEM_BASE(32'h1001_0000), .IO_BASE(32'h1003_0000)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic        rd, wr;
    logic [31:0] wd;
    logic        en;
    logic        chk_rd;
    logic [31:0] rdata;
    logic [15:0] led;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(logic r, logic [31:0] a, logic rd, logic wr, logic [31:0] wd,
                             logic en, logic c, logic [31:0] rdat, logic [15:0] l);
    vec_t t;
    t.rst = r; t.addr = a; t.rd = rd; t.wr = wr; t.wd = wd;
    t.en = en; t.chk_rd = c; t.rdata = rdat; t.led = l;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic drive(logic r, logic [31:0] a, logic rd, logic wr, logic [31:0] wd);
    reset             = r;
    bus.mem_addr      = a;
    bus.mem_rd        = rd;
    bus.mem_wr        = wr;
    bus.mem_writedata = wd;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [NLOC];
  logic [15:0] m_led;
  logic [31:0] m_cyc;
  logic        m_err;
  logic [15:0] m_stall;
  logic        m_pend;
  logic [31:0] m_pdata;

  // 0 unmapped, 1 dmem, 2 led, 3 cycle, 4 status, 5 stall counter
  function automatic int kind(logic [31:0] a);
    if (a[1:0] != 2'b00) return 0;
    if (a >= DB && a < DB + 32'(NLOC * 4)) return 1;
    if (a == 32'h1003_0000) return 2;
    if (a == 32'h1003_0004) return 3;
    if (a == 32'h1003_0008) return 4;
`ifdef STALL_COUNT_EN
    if (a == 32'h1003_000C) return 5;
`endif
    return 0;
  endfunction

  task automatic rstep(logic r, logic [31:0] a, logic rd, logic wr, logic [31:0] wd);
    int          k;
    int          idx;
    logic        e_en;
    logic        c_rd;
    logic [31:0] e_rd;
    k    = kind(a);
    idx  = int'((a - DB) >> 2);
    e_en = 1'b1; c_rd = 1'b1; e_rd = 32'd0;
    if (m_pend) e_rd = m_pdata;
    else if (!wr && rd) begin
      case (k)
        1: begin e_en = 1'b0; c_rd = 1'b0; end
        2: e_rd = {16'd0, m_led};
        3: e_rd = m_cyc;
        4: e_rd = {31'd0, m_err};
        5: e_rd = {16'd0, m_stall};
        default: e_rd = 32'd0;
      endcase
    end
    drive(r, a, rd, wr, wd);
    @(negedge clk);
    if (!r) begin
      chk("rnd.cpu_enable", {31'd0, bus.cpu_enable}, {31'd0, e_en});
      if (c_rd) chk("rnd.readdata", bus.mem_readdata, e_rd);
      chk("rnd.led", {16'd0, led}, {16'd0, m_led});
    end
    @(posedge clk);
    if (r) begin
      m_led = 16'd0; m_cyc = 32'd0; m_err = 1'b0; m_stall = 16'd0; m_pend = 1'b0;
    end else begin
      m_cyc = m_cyc + 32'd1;
      if (!e_en && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (m_pend) m_pend = 1'b0;
      else if (wr) begin
        case (k)
          1: m_ram[idx] = wd;
          2: m_led = wd[15:0];
          3: m_cyc = wd;
          4: if (wd[0]) m_err = 1'b0;
          5: m_stall = 16'd0;
          default: m_err = 1'b1;
        endcase
      end else if (rd) begin
        if (k == 1) begin m_pend = 1'b1; m_pdata = m_ram[idx]; end
        else if (k == 0) m_err = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] a, wd;
    logic        rd, wr, r;

    // directed vectors, one row per cycle
    tv.push_back(v(0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h0,        16'h0));
    tv.push_back(v(0, 32'h1001_0008, 0, 1, 32'h1234_5678, 1, 1, 32'h0,        16'h0));
    tv.push_back(v(0, 32'h1001_0008, 1, 0, 32'h0,         0, 0, 32'h0,        16'h0));
    tv.push_back(v(0, 32'h1001_0008, 1, 0, 32'h0,         1, 1, 32'h1234_5678,16'h0));
    tv.push_back(v(0, 32'h1003_0000, 0, 1, 32'h0000_ABCD, 1, 1, 32'h0,        16'h0));
    tv.push_back(v(0, 32'h1003_0000, 1, 0, 32'h0,         1, 1, 32'h0000_ABCD,16'hABCD));
    tv.push_back(v(0, 32'h1003_0004, 0, 1, 32'hFFFF_FFFE, 1, 1, 32'h0,        16'hABCD));
    for (int i = 0; i < 3; i++)
      tv.push_back(v(0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h0, 16'hABCD));
    tv.push_back(v(0, 32'h1003_0004, 1, 0, 32'h0,         1, 1, 32'h1,        16'hABCD));
    tv.push_back(v(0, 32'h1001_0002, 1, 0, 32'h0,         1, 1, 32'h0,        16'hABCD));
    tv.push_back(v(0, 32'h1001_0100, 1, 0, 32'h0,         1, 1, 32'h0,        16'hABCD));
    tv.push_back(v(0, 32'h1003_0008, 1, 0, 32'h0,         1, 1, 32'h1,        16'hABCD));
    tv.push_back(v(0, 32'h1003_0008, 0, 1, 32'h1,         1, 1, 32'h0,        16'hABCD));
    tv.push_back(v(0, 32'h1003_0008, 1, 0, 32'h0,         1, 1, 32'h0,        16'hABCD));
    tv.push_back(v(0, 32'h1001_0009, 0, 1, 32'h5,         1, 1, 32'h0,        16'hABCD));
    tv.push_back(v(0, 32'h1003_0008, 1, 0, 32'h0,         1, 1, 32'h1,        16'hABCD));
    // reset during LOAD_WAIT
    tv.push_back(v(0, 32'h1001_0008, 1, 0, 32'h0,         0, 0, 32'h0,        16'hABCD));
    tv.push_back(v(1, 32'h1001_0008, 1, 0, 32'h0,         1, 0, 32'h0,        16'hABCD));
    tv.push_back(v(0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h0,        16'h0));
    tv.push_back(v(0, 32'h1003_0008, 1, 0, 32'h0,         1, 1, 32'h0,        16'h0));
    tv.push_back(v(0, 32'h1001_0008, 1, 0, 32'h0,         0, 0, 32'h0,        16'h0));
    tv.push_back(v(0, 32'h1001_0008, 1, 0, 32'h0,         1, 1, 32'h1234_5678,16'h0));
    // reset beats same-cycle stores
    tv.push_back(v(1, 32'h1001_0008, 0, 1, 32'hDEAD_BEEF, 1, 1, 32'h0,        16'h0));
    tv.push_back(v(1, 32'h1003_0000, 0, 1, 32'h0000_FFFF, 1, 1, 32'h0,        16'h0));
    tv.push_back(v(0, 32'h1003_0000, 1, 0, 32'h0,         1, 1, 32'h0,        16'h0));
    tv.push_back(v(0, 32'h1001_0008, 1, 0, 32'h0,         0, 0, 32'h0,        16'h0));
    tv.push_back(v(0, 32'h1001_0008, 1, 0, 32'h0,         1, 1, 32'h1234_5678,16'h0));
    // stall counter: clear, three back-to-back loads, read
    tv.push_back(v(0, 32'h1003_000C, 0, 1, 32'h0,         1, 1, 32'h0,        16'h0));
    for (int i = 0; i < 3; i++) begin
      tv.push_back(v(0, 32'h1001_0008, 1, 0, 32'h0, 0, 0, 32'h0,         16'h0));
      tv.push_back(v(0, 32'h1001_0008, 1, 0, 32'h0, 1, 1, 32'h1234_5678, 16'h0));
    end
    tv.push_back(v(0, 32'h1003_000C, 1, 0, 32'h0,         1, 1, EXP_STALL,    16'h0));
    tv.push_back(v(0, 32'h1003_0008, 1, 0, 32'h0,         1, 1, EXP_STAT,     16'h0));

    drive(1, 32'h0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].addr, tv[i].rd, tv[i].wr, tv[i].wd);
      @(negedge clk);
      chk($sformatf("vec%0d.cpu_enable", i), {31'd0, bus.cpu_enable}, {31'd0, tv[i].en});
      if (tv[i].chk_rd) chk($sformatf("vec%0d.readdata", i), bus.mem_readdata, tv[i].rdata);
      chk($sformatf("vec%0d.led", i), {16'd0, led}, {16'd0, tv[i].led});
      @(posedge clk);
      #1;
    end

    // randomized run against the model
    m_pend = 1'b0;
    rstep(1, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < NLOC; i++) rstep(0, DB + 32'(i * 4), 0, 1, $urandom);
    a = 32'h0; rd = 1'b0; wr = 1'b0; wd = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 63) == 0);
      if (!m_pend) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: a = DB + 32'(4 * $urandom_range(0, NLOC - 1));
          4: a = 32'h1003_0000;
          5: a = 32'h1003_0004;
          6: a = 32'h1003_0008;
          7: a = 32'h1003_000C;
          8: a = DB + 32'(4 * $urandom_range(NLOC, 16383)) + 32'($urandom_range(0, 1));
          default: a = $urandom;
        endcase
        rd = 1'($urandom_range(0, 1));
        wr = ($urandom_range(0, 2) == 0);
        wd = $urandom;
      end
      rstep(r, a, rd, wr, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the single-cycle MIPS datapath's data port. It serves the datapath's mem_addr / mem_writedata / mem_readdata interface.
- Decodes each CPU access to one of three targets: synchronous-read data RAM, a small memory-mapped I/O register bank, or unmapped space.
- Loads that hit data RAM take two cycles. The block drives the datapath enable low for one cycle so the PC holds while the RAM read completes.
- The integrator gates werf with cpu_enable. Stores and I/O accesses complete in a single cycle.

Parameters:
- Nloc, 64, number of 32-bit words in the data RAM (power of two).
- Dbits, 32, data width.
- DMEM_BASE, 32'h10010000, data RAM base address (upper 16 bits decoded).
- IO_BASE, 32'h10030000, I/O bank base address (upper 16 bits decoded).

Ports:
- clk  input  1  system clock, all state on posedge
- reset  input  1  synchronous, active-high
- mem_addr  input  32  byte address from the datapath ALU result
- mem_rd  input  1  load request (lw)
- mem_wr  input  1  store request (sw)
- mem_writedata  input  Dbits  store data
- mem_readdata  output  Dbits  load data to the datapath
- cpu_enable  output  1  datapath enable; 0 = stall the PC this cycle
- led  output  16  LED register contents

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). There are no asynchronous paths.
- Reset values: state=IDLE, cpu_enable=1, mem_readdata=0, led=0, cycle counter=0, err=0. RAM contents are not reset.
- Address decode: misaligned accesses (mem_addr[1:0]!=0) are always unmapped.
  - DMEM hit: mem_addr[31:16]==DMEM_BASE[31:16] and word index mem_addr[15:2] < Nloc. RAM index = mem_addr[$clog2(Nloc)+1:2].
  - IO hit: mem_addr[31:16]==IO_BASE[31:16] and offset mem_addr[15:0] is one of the registers below.
  - Anything else is unmapped.
- I/O registers (offset from IO_BASE):
  - 0x0 LED: read/write; low 16 bits stored; reads are zero-extended.
  - 0x4 CYCLE: 32-bit free-running counter, +1 every cycle, including stall cycles. Wraps 0xFFFFFFFF->0. A write loads mem_writedata; the following cycle reads the written value.
  - 0x8 STATUS: bit0 = err (sticky), bit1 = (state==LOAD_WAIT), other bits 0. A write with bit0=1 clears err; other written bits are ignored.
- FSM states: IDLE, LOAD_WAIT.
  - IDLE, mem_wr=1: the store executes at the clock edge (RAM write, I/O write, or unmapped-store handling). No stall. Any mem_rd in the same cycle is ignored; writes take priority.
  - IDLE, mem_rd=1 with a DMEM hit: RAM read issued this cycle; cpu_enable=0 combinationally; next state LOAD_WAIT.
  - IDLE, mem_rd=1 with an IO hit: mem_readdata is the register value combinationally; cpu_enable=1; stays IDLE.
  - IDLE, mem_rd=1 unmapped: mem_readdata=0; err set at the edge; cpu_enable=1.
  - IDLE, no request: mem_readdata=0.
  - LOAD_WAIT: mem_readdata = RAM output register; cpu_enable=1; next state IDLE unconditionally. The repeated mem_rd/mem_wr inputs are ignored, because they belong to the same held instruction.
- Load latency: exactly 1 stall cycle per DMEM load; data is valid in the second cycle.
- Back-to-back DMEM loads each stall once.
- Store-then-load to the same address: the load returns the stored value (the RAM write precedes the read edge).
- Unmapped store: dropped, err set.
- reset asserted in LOAD_WAIT: next cycle is IDLE with cpu_enable=1. The pending load is discarded; RAM is unchanged.
- reset has priority over all writes, including a same-cycle store.

Optional Feature:
- Macro: STALL_COUNT_EN.
- Defined: adds a 16-bit stall counter at IO offset 0xC.
  - Increments on every cycle with cpu_enable=0 and saturates at 0xFFFF.
  - Any write to 0xC clears it to 0. Reads are zero-extended. Reset value 0.
- Undefined: offset 0xC is unmapped (reads 0, sets err) and no counter logic is generated.

Test Plan:
- Reset, then sw 0x12345678 to 0x10010008, then lw 0x10010008 -> no stall on the store; load shows cpu_enable=0 for 1 cycle, then mem_readdata=0x12345678 with cpu_enable=1.
- sw 0x0000ABCD to 0x10030000, lw 0x10030000 -> led=0xABCD from the next cycle; read returns 0x0000ABCD with no stall.
- sw 0xFFFFFFFE to 0x10030004, then idle 3 cycles, lw 0x10030004 -> counter wraps; read returns 0x00000001.
- lw 0x10010002 (misaligned), then lw 0x10030008 -> first returns 0 with no stall; STATUS reads 0x1. sw 0x1 to 0x10030008 -> STATUS reads 0x0.
- DMEM lw issued, reset asserted in the LOAD_WAIT cycle -> next cycle state IDLE, cpu_enable=1, mem_readdata=0; previously stored RAM word still readable.
- STALL_COUNT_EN defined, three DMEM loads back-to-back -> 0x1003000C reads 3. STALL_COUNT_EN undefined -> the same read returns 0 and sets err.
